cache_merge4_arb: RTL and testbench
===================================

// Module: cache_merge4_arb
// PURPOSE
//  Synchronous 4-to-1 drive/free merge for the cache control path; counterpart of the 4-way
//  valid-steered fork. Collects drive pulses from four upstream channels, round-robin picks one,
//  issues a single delayed drive pulse downstream, then returns the downstream free to the winner.
//  Sits where fork branches (hit/miss/refill/writeback) reconverge onto one shared stage.
// PARAMETERS
//  DELAY    2     cycles from grant (o_fire) to o_driveNext; legal 1..15. Matches the downstream settle time.
//  TIMEOUT  255   WAIT_FREE cycles before o_timeout asserts (used only with macro); legal 1..65535
// PORTS
//  clk          in   1  single clock, all logic on rising edge
//  rst          in   1  asynchronous, active-high reset
//  i_drive      in   4  per-channel request pulse (1 cycle = 1 request)
//  o_free       out  4  per-channel completion pulse, 1 cycle, to granted channel only
//  o_fire       out  1  1-cycle pulse on grant
//  o_sel        out  2  granted channel index, stable from grant until RELEASE ends
//  o_driveNext  out  1  1-cycle drive pulse to downstream stage
//  i_freeNext   in   1  downstream completion pulse
//  o_busy       out  1  high whenever state != IDLE
//  o_overrun    out  1  sticky: drive arrived on a channel already pending; cleared only by rst
//  o_timeout    out  1  sticky watchdog flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, pending=0, last=3 (so ch0 wins first), cnt=0; every output 0, o_sel=0.
//  pending[k] set by i_drive[k]; cleared when k granted. Set and clear same cycle -> set wins.
//  i_drive[k] with pending[k] already 1 -> request dropped, o_overrun<=1.
//  Round-robin: search order last+1, last+2, ... mod 4 (2-bit wrap); winner becomes last.
//  FSM (registered; outputs are registered):
//   IDLE      pending!=0 -> grant: o_sel<=idx, pending[idx]<=0, o_fire=1 next cycle, cnt<=DELAY, ->DELAY
//             A request arriving in cycle T is first visible to arbitration in T+1.
//   DELAY     cnt decrements; o_driveNext high exactly in cycle grant+DELAY, then ->WAIT_FREE
//   WAIT_FREE i_freeNext=1 -> RELEASE; other cycles hold
//   RELEASE   o_free[o_sel]=1 for one cycle, ->IDLE; next grant at earliest the following cycle
//  i_freeNext outside WAIT_FREE (including the o_driveNext cycle) ignored.
//  A new i_drive on the currently granted channel is accepted as a fresh pending request.
//  o_free is never asserted on more than one bit; o_fire/o_driveNext/o_free never overlap.
//  rst mid-transaction: immediate abort, all pending discarded, no o_free emitted.
// CONFIGURATION
//  CACHE_MERGE4_WATCHDOG_EN defined: 16-bit counter clears on entry to WAIT_FREE, counts each
//   WAIT_FREE cycle; reaching TIMEOUT sets o_timeout (sticky until rst), FSM forced to RELEASE
//   so the winner still receives o_free (recovery). Counter saturates, never wraps.
//  Not defined: no counter logic, o_timeout tied 0, WAIT_FREE waits indefinitely.
// TESTING
//  1 rst, i_drive=4'b0100 at T -> o_fire T+2, o_sel=2, o_driveNext T+4 (DELAY=2); i_freeNext at T+7 -> o_free=4'b0100 at T+8 only.
//  2 i_drive=4'b1111 same cycle after rst -> grants ch0,1,2,3 in order, each o_free once, pending=0 at end.
//  3 ch1 served (last=1), then i_drive=4'b1001 -> ch3 granted before ch0 (wrap 3->0 checked).
//  4 i_drive[2] pulsed twice while ch0 busy -> o_overrun=1, ch2 served exactly once.
//  5 i_freeNext during DELAY -> ignored, FSM stays until a later i_freeNext; assert rst in WAIT_FREE -> all outputs 0 next edge, no o_free.
//  6 WATCHDOG_EN, TIMEOUT=8, no i_freeNext -> o_timeout=1 after 8 WAIT_FREE cycles, o_free pulse to winner; without macro o_timeout stays 0.

Source files
------------

// File: rtl/cache_merge4_arb.sv
// 4-to-1 round-robin drive/free merge: one delayed downstream drive per grant, free returned to the winner.
// Optional WAIT_FREE watchdog enabled by defining CACHE_MERGE4_WATCHDOG_EN.
module cache_merge4_arb #(
    parameter int DELAY   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_drive,
    output logic [3:0] o_free,
    output logic       o_fire,
    output logic [1:0] o_sel,
    output logic       o_driveNext,
    input  logic       i_freeNext,
    output logic       o_busy,
    output logic       o_overrun,
    output logic       o_timeout
);

    if (DELAY < 1 || DELAY > 15 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("cache_merge4_arb: DELAY or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_DLY, S_WAIT, S_REL} state_t;

    state_t     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] sel_d;
    logic [1:0] win;
    logic [3:0] grant_mask;
    logic [3:0] free_d;
    logic       fire_d, drive_d, overrun_d;

`ifdef CACHE_MERGE4_WATCHDOG_EN
    logic [15:0] wd_q, wd_d, wd_inc;
    logic        timeout_d;
`endif

    // Walk from farthest to nearest so the nearest pending channel after last wins.
    always_comb begin
        win = last_q;
        for (int i = 4; i >= 1; i--) begin
            if (pending_q[last_q + 2'(i)]) win = last_q + 2'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        sel_d      = o_sel;
        grant_mask = 4'b0000;
        free_d     = 4'b0000;
        fire_d     = 1'b0;
        drive_d    = 1'b0;
`ifdef CACHE_MERGE4_WATCHDOG_EN
        wd_d      = wd_q;
        wd_inc    = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
        timeout_d = o_timeout;
`endif
        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    state_d    = S_DLY;
                    sel_d      = win;
                    last_d     = win;
                    grant_mask = 4'b0001 << win;
                    fire_d     = 1'b1;
                    cnt_d      = 4'(DELAY);
                end
            end
            S_DLY: begin
                // Drive goes out while cnt hits 0; WAIT_FREE starts the cycle after it.
                if (cnt_q == 4'd1) begin
                    drive_d = 1'b1;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_WAIT;
`ifdef CACHE_MERGE4_WATCHDOG_EN
                    wd_d = 16'd0;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WAIT: begin
                if (i_freeNext) begin
                    state_d = S_REL;
                    free_d  = 4'b0001 << o_sel;
                end
`ifdef CACHE_MERGE4_WATCHDOG_EN
                else begin
                    wd_d = wd_inc;
                    if (32'(wd_inc) >= TIMEOUT) begin
                        timeout_d = 1'b1;
                        state_d   = S_REL;
                        free_d    = 4'b0001 << o_sel;
                    end
                end
`endif
            end
            S_REL: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A request landing on the channel being granted this cycle is kept as a new request.
        pending_d = (pending_q & ~grant_mask) | i_drive;
        overrun_d = o_overrun | (|(i_drive & pending_q & ~grant_mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pending_q   <= 4'b0000;
            last_q      <= 2'd3;
            cnt_q       <= 4'd0;
            o_sel       <= 2'd0;
            o_fire      <= 1'b0;
            o_driveNext <= 1'b0;
            o_free      <= 4'b0000;
            o_overrun   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            o_sel       <= sel_d;
            o_fire      <= fire_d;
            o_driveNext <= drive_d;
            o_free      <= free_d;
            o_overrun   <= overrun_d;
        end
    end

`ifdef CACHE_MERGE4_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q      <= 16'd0;
            o_timeout <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            o_timeout <= timeout_d;
        end
    end
`else
    assign o_timeout = 1'b0;
`endif

    assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_merge4_arb.sv
// Directed bench for cache_merge4_arb (DELAY=2, TIMEOUT=8); inputs driven and outputs sampled on negedge.
module tb_cache_merge4_arb;

    logic       clk;
    logic       rst;
    logic [3:0] i_drive;
    logic [3:0] o_free;
    logic       o_fire;
    logic [1:0] o_sel;
    logic       o_driveNext;
    logic       i_freeNext;
    logic       o_busy;
    logic       o_overrun;
    logic       o_timeout;

    int checks;
    int errors;

    cache_merge4_arb #(.DELAY(2), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_drive    (i_drive),
        .o_free     (o_free),
        .o_fire     (o_fire),
        .o_sel      (o_sel),
        .o_driveNext(o_driveNext),
        .i_freeNext (i_freeNext),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun),
        .o_timeout  (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst        = 1'b1;
        i_drive    = 4'b0000;
        i_freeNext = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_free !== 4'b0000 || o_fire !== 1'b0 || o_driveNext !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses free=%b fire=%b drv=%b expected 0000/0/0", o_free, o_fire, o_driveNext);
        end
        checks++;
        if (o_sel !== 2'd0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_sel_busy sel=%0d busy=%b expected 0/0", o_sel, o_busy);
        end
        checks++;
        if (o_overrun !== 1'b0 || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags overrun=%b timeout=%b expected 0/0", o_overrun, o_timeout);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Waits for a grant, then walks it through drive and free, expecting channel ch.
    task automatic serve(input int ch);
        int         n;
        logic [3:0] exp_free;
        exp_free = 4'b0001 << ch;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_fire && n < 20);
        checks++;
        if (o_fire !== 1'b1) begin
            errors++;
            $display("FAIL serve_grant ch%0d fire=%b expected 1 within 20 cycles", ch, o_fire);
        end
        checks++;
        if (o_sel !== 2'(ch)) begin
            errors++;
            $display("FAIL serve_sel got %0d expected %0d", o_sel, ch);
        end
        @(negedge clk);
        checks++;
        if (o_driveNext !== 1'b0) begin
            errors++;
            $display("FAIL serve_drive_early ch%0d drv=%b expected 0", ch, o_driveNext);
        end
        @(negedge clk);
        checks++;
        if (o_driveNext !== 1'b1) begin
            errors++;
            $display("FAIL serve_drive ch%0d drv=%b expected 1", ch, o_driveNext);
        end
        @(negedge clk);
        i_freeNext = 1'b1;
        @(negedge clk);
        i_freeNext = 1'b0;
        checks++;
        if (o_free !== exp_free) begin
            errors++;
            $display("FAIL serve_free got %b expected %b", o_free, exp_free);
        end
        @(negedge clk);
        checks++;
        if (o_free !== 4'b0000 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL serve_release free=%b busy=%b expected 0000/0", o_free, o_busy);
        end
    endtask

    task automatic test_single();
        test_reset();
        i_drive = 4'b0100;                       // cycle T
        @(negedge clk); i_drive = 4'b0000;       // T+1
        checks++;
        if (o_fire !== 1'b0) begin errors++; $display("FAIL single_fire_early fire=%b expected 0", o_fire); end
        @(negedge clk);                          // T+2
        checks++;
        if (o_fire !== 1'b1 || o_sel !== 2'd2 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant fire=%b sel=%0d busy=%b expected 1/2/1", o_fire, o_sel, o_busy);
        end
        @(negedge clk);                          // T+3
        checks++;
        if (o_fire !== 1'b0 || o_driveNext !== 1'b0) begin
            errors++;
            $display("FAIL single_t3 fire=%b drv=%b expected 0/0", o_fire, o_driveNext);
        end
        @(negedge clk);                          // T+4
        checks++;
        if (o_driveNext !== 1'b1) begin errors++; $display("FAIL single_drive drv=%b expected 1", o_driveNext); end
        @(negedge clk);                          // T+5
        checks++;
        if (o_driveNext !== 1'b0) begin errors++; $display("FAIL single_drive_once drv=%b expected 0", o_driveNext); end
        @(negedge clk);                          // T+6
        @(negedge clk); i_freeNext = 1'b1;       // T+7
        checks++;
        if (o_free !== 4'b0000) begin errors++; $display("FAIL single_free_early free=%b expected 0000", o_free); end
        @(negedge clk); i_freeNext = 1'b0;       // T+8
        checks++;
        if (o_free !== 4'b0100) begin errors++; $display("FAIL single_free free=%b expected 0100", o_free); end
        @(negedge clk);                          // T+9
        checks++;
        if (o_free !== 4'b0000 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle free=%b busy=%b expected 0000/0", o_free, o_busy);
        end
    endtask

    task automatic test_all_four();
        logic saw_fire;
        test_reset();
        i_drive = 4'b1111;
        @(negedge clk); i_drive = 4'b0000;
        for (int c = 0; c < 4; c++) serve(c);
        saw_fire = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_fire) saw_fire = 1'b1;
        end
        checks++;
        if (saw_fire !== 1'b0) begin errors++; $display("FAIL all_four_drained extra grant seen=%b expected 0", saw_fire); end
    endtask

    task automatic test_wrap();
        test_reset();
        i_drive = 4'b0010;
        @(negedge clk); i_drive = 4'b0000;
        serve(1);
        i_drive = 4'b1001;
        @(negedge clk); i_drive = 4'b0000;
        serve(3);
        serve(0);
    endtask

    task automatic test_overrun();
        logic saw_fire;
        test_reset();
        i_drive = 4'b0001;                       // T
        @(negedge clk); i_drive = 4'b0100;       // T+1
        @(negedge clk); i_drive = 4'b0000;       // T+2
        checks++;
        if (o_fire !== 1'b1 || o_sel !== 2'd0) begin
            errors++;
            $display("FAIL overrun_grant0 fire=%b sel=%0d expected 1/0", o_fire, o_sel);
        end
        @(negedge clk); i_drive = 4'b0100;       // T+3, second pulse while pending
        checks++;
        if (o_overrun !== 1'b0) begin errors++; $display("FAIL overrun_early overrun=%b expected 0", o_overrun); end
        @(negedge clk); i_drive = 4'b0000;       // T+4
        checks++;
        if (o_overrun !== 1'b1 || o_driveNext !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set overrun=%b drv=%b expected 1/1", o_overrun, o_driveNext);
        end
        @(negedge clk); i_freeNext = 1'b1;       // T+5
        @(negedge clk); i_freeNext = 1'b0;       // T+6
        checks++;
        if (o_free !== 4'b0001) begin errors++; $display("FAIL overrun_free0 free=%b expected 0001", o_free); end
        serve(2);
        saw_fire = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (o_fire) saw_fire = 1'b1;
        end
        checks++;
        if (saw_fire !== 1'b0 || o_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_once extra_grant=%b overrun=%b expected 0/1", saw_fire, o_overrun);
        end
    endtask

    task automatic test_ignore_and_abort();
        logic bad;
        int   n;
        test_reset();
        i_drive = 4'b0001;                       // T
        @(negedge clk); i_drive = 4'b0000;       // T+1
        @(negedge clk);                          // T+2 grant
        @(negedge clk); i_freeNext = 1'b1;       // T+3 in DELAY
        @(negedge clk);                          // T+4 drive cycle, still ignored
        checks++;
        if (o_driveNext !== 1'b1) begin errors++; $display("FAIL ignore_drive drv=%b expected 1", o_driveNext); end
        @(negedge clk); i_freeNext = 1'b0; i_drive = 4'b0010;   // T+5
        @(negedge clk); i_drive = 4'b0000;       // T+6
        bad = (o_free !== 4'b0000) || (o_busy !== 1'b1);
        @(negedge clk); i_freeNext = 1'b1;       // T+7
        if (o_free !== 4'b0000 || o_busy !== 1'b1) bad = 1'b1;
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL ignore_early_free premature release=%b expected 0", bad); end
        @(negedge clk); i_freeNext = 1'b0;       // T+8
        checks++;
        if (o_free !== 4'b0001) begin errors++; $display("FAIL ignore_late_free free=%b expected 0001", o_free); end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_fire && n < 20);
        checks++;
        if (o_fire !== 1'b1 || o_sel !== 2'd1) begin
            errors++;
            $display("FAIL abort_grant1 fire=%b sel=%0d expected 1/1", o_fire, o_sel);
        end
        @(negedge clk); i_drive = 4'b1000;       // G+1
        @(negedge clk); i_drive = 4'b0000;       // G+2
        @(negedge clk);                          // G+3 WAIT_FREE
        @(negedge clk); rst = 1'b1;              // G+4
        @(negedge clk);
        checks++;
        if (o_free !== 4'b0000 || o_fire !== 1'b0 || o_driveNext !== 1'b0 || o_busy !== 1'b0 || o_sel !== 2'd0) begin
            errors++;
            $display("FAIL abort_outputs free=%b fire=%b drv=%b busy=%b sel=%0d expected all 0",
                     o_free, o_fire, o_driveNext, o_busy, o_sel);
        end
        rst = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (o_fire || (o_free != 4'b0000)) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL abort_discard activity after reset=%b expected 0", bad); end
    endtask

    task automatic test_watchdog();
        int   n;
        logic bad;
        test_reset();
        i_drive = 4'b0001;
        @(negedge clk); i_drive = 4'b0000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_fire && n < 20);
`ifdef CACHE_MERGE4_WATCHDOG_EN
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_free == 4'b0000 && n < 30);
        checks++;
        if (o_free !== 4'b0001 || o_timeout !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_recover free=%b timeout=%b expected 0001/1", o_free, o_timeout);
        end
        checks++;
        if (n !== 11) begin errors++; $display("FAIL watchdog_latency cycles=%0d expected 11", n); end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_timeout !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_sticky busy=%b timeout=%b expected 0/1", o_busy, o_timeout);
        end
`else
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (o_timeout || (o_free != 4'b0000)) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL nowatchdog_hold early_exit=%b busy=%b expected 0/1", bad, o_busy);
        end
        i_freeNext = 1'b1;
        @(negedge clk); i_freeNext = 1'b0;
        checks++;
        if (o_free !== 4'b0001 || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL nowatchdog_free free=%b timeout=%b expected 0001/0", o_free, o_timeout);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_overrun();
        test_ignore_and_abort();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
